// File: rtl/seg7_scan_driver.sv
// Six-digit common-anode scan driver: snapshots a frame of segment codes at frame start,
// then multiplexes them with a per-slot blanking guard, per-digit blink and PWM dimming.
module seg7_scan_driver #(
  parameter int          CLK_HZ   = 50_000_000,
  parameter int          DIGIT_HZ = 6000,
  parameter int          GUARD    = 16,
  parameter int          BLINK_HZ = 2,
  parameter logic [5:0]  DP_MASK  = 6'b010100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] sec_low,
  input  logic [6:0] sec_high,
  input  logic [6:0] min_low,
  input  logic [6:0] min_high,
  input  logic [6:0] hr_low,
  input  logic [6:0] hr_high,
  input  logic [5:0] blink_mask,
  input  logic [3:0] brightness,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] dig_n,
  output logic       frame_done
);

  localparam int DIV  = CLK_HZ / DIGIT_HZ;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int TW   = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [TW-1:0]   tick;
  logic [2:0]      idx;
  logic [3:0]      pwm;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;
  logic [5:0][6:0] frame;
  logic [5:0][6:0] codes;
  logic            on_c, snap_c, tick_last, blink_last;

  assign codes      = {hr_high, hr_low, min_high, min_low, sec_high, sec_low};
  assign tick_last  = (tick == TW'(DIV - 1));
  assign blink_last = (blink_cnt == BW'(HALF - 1));
  // tick==0 sits inside the guard, so the new snapshot is never shown on the edge it is taken
  assign snap_c     = (tick == '0) && (idx == 3'd0);
  assign on_c       = (int'(tick) >= GUARD) && !(blink_mask[idx] && blink_phase) &&
                      ((brightness == 4'hF) || (pwm < brightness));

  // Blink timebase keeps running while the display is disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_last) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick       <= '0;
      idx        <= 3'd0;
      pwm        <= 4'd0;
      frame      <= '0;
      dig_n      <= 6'h3F;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else if (!enable) begin
      tick       <= '0;
      idx        <= 3'd0;
      pwm        <= 4'd0;
      dig_n      <= 6'h3F;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      pwm        <= pwm + 1'b1;
      frame_done <= snap_c;
      if (snap_c) frame <= codes;
      if (tick_last) begin
        tick <= '0;
        idx  <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        tick <= tick + 1'b1;
      end
      if (on_c) begin
        dig_n <= ~(6'd1 << idx);
        seg_n <= ~frame[idx];
        dp_n  <= ~DP_MASK[idx];
      end else begin
        dig_n <= 6'h3F;
        seg_n <= 7'h7F;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count based display model.
module tb_seg7_scan_driver;

  localparam logic [5:0] DPM = 6'b010100;

  logic       clk, rst, enable;
  logic [6:0] sec_low, sec_high, min_low, min_high, hr_low, hr_high;
  logic [5:0] blink_mask;
  logic [3:0] brightness;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] dig_n;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.CLK_HZ(600), .DIGIT_HZ(60), .GUARD(2), .BLINK_HZ(5), .DP_MASK(DPM)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sec_low(sec_low), .sec_high(sec_high), .min_low(min_low), .min_high(min_high),
    .hr_low(hr_low), .hr_high(hr_high), .blink_mask(blink_mask), .brightness(brightness),
    .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: n = enabled cycles since (re)start, bc = cycles since reset.
  // Frame is 60 cycles, 10 per digit, lit from slot offset 2; blink phase flips every 60 cycles.
  int         n, bc;
  logic [6:0] mf [6];
  logic [5:0] exp_dig;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_fd;

  function automatic logic lit_f(int nn, int bb, logic [5:0] bm, logic [3:0] br);
    int pos, d;
    logic ph;
    pos = nn % 60;
    d   = pos / 10;
    ph  = ((bb / 60) % 2) == 1;
    return ((pos % 10) >= 2) && !(bm[d[2:0]] && ph) && ((br == 4'd15) || ((nn % 16) < int'(br)));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n <= 0; bc <= 0;
      exp_dig <= 6'h3F; exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_fd <= 1'b0;
      mf <= '{default: 7'h00};
    end else begin
      bc <= bc + 1;
      if (!enable) begin
        n <= 0;
        exp_dig <= 6'h3F; exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_fd <= 1'b0;
      end else begin
        n <= n + 1;
        exp_fd <= (n % 60) == 0;
        if ((n % 60) == 0) mf <= '{sec_low, sec_high, min_low, min_high, hr_low, hr_high};
        if (lit_f(n, bc, blink_mask, brightness)) begin
          exp_dig <= ~(6'd1 << ((n % 60) / 10));
          exp_seg <= ~mf[(n % 60) / 10];
          exp_dp  <= ~DPM[(n % 60) / 10];
        end else begin
          exp_dig <= 6'h3F; exp_seg <= 7'h7F; exp_dp <= 1'b1;
        end
      end
    end
  end

  task automatic rand_codes();
    sec_low = 7'($urandom); sec_high = 7'($urandom); min_low = 7'($urandom);
    min_high = 7'($urandom); hr_low = 7'($urandom); hr_high = 7'($urandom);
  endtask

  task automatic wait_pos(input int p, input string tag);
    int w = 0;
    while ((n % 60) != p && w < 300) begin @(negedge clk); w++; end
    if (w >= 300) begin
      errors++; checks++;
      $display("FAIL %s_timeout: frame position %0d never reached", tag, p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; brightness = 4'd15; blink_mask = 6'd0;
    hr_high = 7'b0110000; hr_low = 7'b1101101; min_high = 7'b1111001;
    min_low = 7'b0110011; sec_high = 7'b1011111; sec_low = 7'b1011011;
    repeat (2) @(negedge clk);
    checks++;
    if ({dig_n, seg_n, dp_n, frame_done} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got dig=%h seg=%h dp=%b fd=%b", dig_n, seg_n, dp_n, frame_done);
    end
    rst = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== {exp_dig, exp_seg, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL reset_scan e%0d: got %h/%h/%b/%b exp %h/%h/%b/%b", e,
                 dig_n, seg_n, dp_n, frame_done, exp_dig, exp_seg, exp_dp, exp_fd);
      end
      if (e == 1) begin
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL first_frame_done: got %b exp 1", frame_done); end
      end
      if (e == 3 || e == 10) begin
        checks++;
        if ({dig_n, seg_n, dp_n} !== {6'b111110, ~7'b1011011, 1'b1}) begin
          errors++; $display("FAIL digit0_e%0d: got dig=%b seg=%b dp=%b", e, dig_n, seg_n, dp_n);
        end
      end
      if (e == 11) begin
        checks++;
        if (dig_n !== 6'h3F) begin errors++; $display("FAIL guard_e11: got dig=%b exp 111111", dig_n); end
      end
      if (e == 13) begin
        checks++;
        if ({dig_n, seg_n} !== {6'b111101, ~7'b1011111}) begin
          errors++; $display("FAIL digit1_e13: got dig=%b seg=%b", dig_n, seg_n);
        end
      end
      if (e == 23 || e == 43) begin
        checks++;
        if (dp_n !== 1'b0) begin errors++; $display("FAIL dp_lit_e%0d: got %b exp 0", e, dp_n); end
      end
    end
  endtask

  task automatic test_tear_free();
    int fdcnt = 0, last = -1, cyc = 0;
    wait_pos(31, "tear");
    sec_low = 7'b1110000;
    repeat (130) begin
      @(negedge clk); cyc++;
      checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== {exp_dig, exp_seg, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL tear_scan: got %h/%h/%b/%b exp %h/%h/%b/%b",
                 dig_n, seg_n, dp_n, frame_done, exp_dig, exp_seg, exp_dp, exp_fd);
      end
      if (frame_done) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 60) begin errors++; $display("FAIL frame_period: got %0d exp 60", cyc - last); end
        end
        last = cyc; fdcnt++;
      end
      if (dig_n == 6'b111110) begin
        checks++;
        if (seg_n !== ((fdcnt == 0) ? ~7'b1011011 : ~7'b1110000)) begin
          errors++; $display("FAIL tear_digit0: got seg=%b after %0d frame starts", seg_n, fdcnt);
        end
      end
    end
    checks++;
    if (fdcnt < 2) begin errors++; $display("FAIL tear_frames: got %0d frame_done pulses exp 2", fdcnt); end
  endtask

  task automatic test_brightness();
    logic [3:0] lv [3];
    lv[0] = 4'd4; lv[1] = 4'($urandom_range(1, 14)); lv[2] = 4'd0;
    for (int k = 0; k < 3; k++) begin
      brightness = lv[k];
      rand_codes();
      repeat (120) begin
        @(negedge clk);
        checks++;
        if ({dig_n, seg_n, dp_n, frame_done} !== {exp_dig, exp_seg, exp_dp, exp_fd}) begin
          errors++;
          $display("FAIL bright%0d_scan: got %h/%h/%b/%b exp %h/%h/%b/%b", lv[k],
                   dig_n, seg_n, dp_n, frame_done, exp_dig, exp_seg, exp_dp, exp_fd);
        end
        if (dig_n !== 6'h3F) begin
          checks++;
          if (((n - 1) % 16) >= int'(lv[k])) begin
            errors++; $display("FAIL bright%0d_pwm: dig=%b lit at pwm %0d", lv[k], dig_n, (n - 1) % 16);
          end
        end
        if (lv[k] == 4'd0) begin
          checks++;
          if (dig_n !== 6'h3F) begin errors++; $display("FAIL bright0_dark: got dig=%b exp 111111", dig_n); end
        end
      end
    end
    brightness = 4'd15;
  endtask

  task automatic test_blink();
    int pos;
    blink_mask = 6'b000011;
    repeat (240) begin
      @(negedge clk);
      checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== {exp_dig, exp_seg, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL blink_scan: got %h/%h/%b/%b exp %h/%h/%b/%b",
                 dig_n, seg_n, dp_n, frame_done, exp_dig, exp_seg, exp_dp, exp_fd);
      end
      pos = (n - 1) % 60;
      if (pos / 10 >= 2 && pos % 10 >= 2) begin
        checks++;
        if (dig_n === 6'h3F) begin errors++; $display("FAIL blink_unmasked: digit %0d dark", pos / 10); end
      end
    end
    blink_mask = 6'($urandom);
    repeat (120) begin
      @(negedge clk);
      checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== {exp_dig, exp_seg, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL blink_rand_scan: mask=%b got %h/%h/%b/%b exp %h/%h/%b/%b", blink_mask,
                 dig_n, seg_n, dp_n, frame_done, exp_dig, exp_seg, exp_dp, exp_fd);
      end
    end
    blink_mask = 6'd0;
  endtask

  task automatic test_enable_reset();
    wait_pos(45, "enable");
    enable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
        errors++; $display("FAIL disabled_dark: got %h/%h/%b/%b", dig_n, seg_n, dp_n, frame_done);
      end
    end
    rand_codes();
    enable = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      @(negedge clk);
      checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== {exp_dig, exp_seg, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL reenable_scan: got %h/%h/%b/%b exp %h/%h/%b/%b",
                 dig_n, seg_n, dp_n, frame_done, exp_dig, exp_seg, exp_dp, exp_fd);
      end
      if (e == 1) begin
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL reenable_snapshot: fd=%b exp 1", frame_done); end
      end
      if (e == 3) begin
        checks++;
        if ({dig_n, seg_n} !== {6'b111110, ~sec_low}) begin
          errors++; $display("FAIL reenable_digit0: got dig=%b seg=%b", dig_n, seg_n);
        end
      end
    end
    wait_pos(25, "areset");
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({dig_n, seg_n, dp_n, frame_done} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL async_reset: got %h/%h/%b/%b", dig_n, seg_n, dp_n, frame_done);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (70) begin
      @(negedge clk);
      checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== {exp_dig, exp_seg, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL post_reset_scan: got %h/%h/%b/%b exp %h/%h/%b/%b",
                 dig_n, seg_n, dp_n, frame_done, exp_dig, exp_seg, exp_dp, exp_fd);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      rand_codes();
      brightness = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
      blink_mask = 6'($urandom);
      repeat (int'($urandom_range(15, 45))) begin
        @(negedge clk);
        checks++;
        if ({dig_n, seg_n, dp_n, frame_done} !== {exp_dig, exp_seg, exp_dp, exp_fd}) begin
          errors++;
          $display("FAIL b2b_scan: got %h/%h/%b/%b exp %h/%h/%b/%b",
                   dig_n, seg_n, dp_n, frame_done, exp_dig, exp_seg, exp_dp, exp_fd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tear_free();
    test_brightness();
    test_blink();
    test_enable_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
